// File: rtl/rv32i_mem_arbiter_pkg.sv
// Shared types for the RV32i fetch/data memory arbiter: FSM state and grant-port encodings.
package rv32i_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2,
    RESP = 2'd3
  } arb_state_t;

  typedef enum logic {
    ARB_PORT_I = 1'b0,
    ARB_PORT_D = 1'b1
  } arb_port_t;

  localparam int ARB_ADDR_W     = 32;
  localparam int ARB_DATA_W     = 32;
  localparam int ARB_STARVE_MAX = 4;

endpackage

// File: rtl/rv32i_mem_arbiter_if.sv
// Core-side (imem_*/dmem_*) and memory-side (mem_*) signals of the arbiter.
// master = arbiter view, slave = view of the core/memory environment around it.
interface rv32i_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   imem_add_i;
  logic                imem_re_i;
  logic [DATA_W-1:0]   imem_data_o;
  logic                imem_valid_o;

  logic [ADDR_W-1:0]   dmem_add_i;
  logic [DATA_W-1:0]   dmem_di_i;
  logic                dmem_we_i;
  logic                dmem_re_i;
  logic [DATA_W/8-1:0] dmem_ble_i;
  logic [DATA_W-1:0]   dmem_do_o;
  logic                dmem_valid_o;

  logic                mem_req_o;
  logic                mem_we_o;
  logic [ADDR_W-1:0]   mem_add_o;
  logic [DATA_W-1:0]   mem_wdata_o;
  logic [DATA_W/8-1:0] mem_ble_o;
  logic [DATA_W-1:0]   mem_rdata_i;
  logic                mem_ack_i;

  modport master (
    input  imem_add_i, imem_re_i,
    output imem_data_o, imem_valid_o,
    input  dmem_add_i, dmem_di_i, dmem_we_i, dmem_re_i, dmem_ble_i,
    output dmem_do_o, dmem_valid_o,
    output mem_req_o, mem_we_o, mem_add_o, mem_wdata_o, mem_ble_o,
    input  mem_rdata_i, mem_ack_i
  );

  modport slave (
    output imem_add_i, imem_re_i,
    input  imem_data_o, imem_valid_o,
    output dmem_add_i, dmem_di_i, dmem_we_i, dmem_re_i, dmem_ble_i,
    input  dmem_do_o, dmem_valid_o,
    input  mem_req_o, mem_we_o, mem_add_o, mem_wdata_o, mem_ble_o,
    output mem_rdata_i, mem_ack_i
  );
endinterface

// File: rtl/rv32i_arb_starve_cnt.sv
// Fetch anti-starvation counter: counts data grants taken while a fetch waits,
// saturates at STARVE_MAX and raises force_fetch; cleared by any fetch grant.
module rv32i_arb_starve_cnt #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic data_grant,
  input  logic fetch_grant,
  input  logic fetch_pending,
  output logic force_fetch
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (fetch_grant) begin
      cnt_q <= '0;
    end else if (data_grant && fetch_pending && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign force_fetch = (cnt_q == CNT_MAX);
endmodule

// File: rtl/rv32i_mem_arbiter.sv
// Single-port memory arbiter between RV32i fetch and data ports; data has priority.
// Define RV32I_ARB_STARVE_EN to force a waiting fetch after STARVE_MAX data grants.
module rv32i_mem_arbiter
  import rv32i_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ARB_ADDR_W,
  parameter int DATA_W     = ARB_DATA_W,
  parameter int STARVE_MAX = ARB_STARVE_MAX
) (
  input logic                 clk_i,
  input logic                 rst_i,
  rv32i_mem_arbiter_if.master bus
);
  // state | meaning
  // IDLE  | no transaction; pick data first, else fetch, latch request
  // IGNT  | fetch on memory bus, waiting for ack
  // DGNT  | load/store on memory bus, waiting for ack
  // RESP  | one-cycle valid pulse to the granted port; no new grant

  localparam int BLE_W = DATA_W / 8;

  if (STARVE_MAX < 1) begin : g_bad_starve
    $error("STARVE_MAX must be at least 1");
  end

  arb_state_t        state_q, state_d;
  arb_port_t         port_q;
  logic              req_we_q;
  logic [ADDR_W-1:0] req_add_q;
  logic [DATA_W-1:0] req_wdata_q;
  logic [BLE_W-1:0]  req_ble_q;
  logic [DATA_W-1:0] imem_data_q;
  logic [DATA_W-1:0] dmem_data_q;

  logic data_req;
  logic grant_d;
  logic grant_i;
  logic force_fetch;

  assign data_req = bus.dmem_we_i | bus.dmem_re_i;

`ifdef RV32I_ARB_STARVE_EN
  rv32i_arb_starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve_cnt (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .data_grant    (grant_d),
    .fetch_grant   (grant_i),
    .fetch_pending (bus.imem_re_i),
    .force_fetch   (force_fetch)
  );
`else
  assign force_fetch = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    grant_d = 1'b0;
    grant_i = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.imem_re_i && force_fetch) begin
          state_d = IGNT;
          grant_i = 1'b1;
        end else if (data_req) begin
          state_d = DGNT;
          grant_d = 1'b1;
        end else if (bus.imem_re_i) begin
          state_d = IGNT;
          grant_i = 1'b1;
        end
      end
      IGNT, DGNT: begin
        if (bus.mem_ack_i) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request fields are frozen at grant so the core may drop its request mid-transaction.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      port_q      <= ARB_PORT_I;
      req_we_q    <= 1'b0;
      req_add_q   <= '0;
      req_wdata_q <= '0;
      req_ble_q   <= '0;
    end else if (grant_d) begin
      port_q      <= ARB_PORT_D;
      req_we_q    <= bus.dmem_we_i;
      req_add_q   <= bus.dmem_add_i;
      req_wdata_q <= bus.dmem_di_i;
      req_ble_q   <= bus.dmem_ble_i;
    end else if (grant_i) begin
      port_q      <= ARB_PORT_I;
      req_we_q    <= 1'b0;
      req_add_q   <= bus.imem_add_i;
      req_wdata_q <= '0;
      req_ble_q   <= '1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      imem_data_q <= '0;
      dmem_data_q <= '0;
    end else if (bus.mem_ack_i) begin
      if (state_q == IGNT)                 imem_data_q <= bus.mem_rdata_i;
      if ((state_q == DGNT) && !req_we_q)  dmem_data_q <= bus.mem_rdata_i;
    end
  end

  assign bus.mem_req_o    = (state_q == IGNT) || (state_q == DGNT);
  assign bus.mem_we_o     = req_we_q & bus.mem_req_o;
  assign bus.mem_add_o    = req_add_q;
  assign bus.mem_wdata_o  = req_wdata_q;
  assign bus.mem_ble_o    = req_ble_q;
  assign bus.imem_data_o  = imem_data_q;
  assign bus.dmem_do_o    = dmem_data_q;
  assign bus.imem_valid_o = (state_q == RESP) && (port_q == ARB_PORT_I);
  assign bus.dmem_valid_o = (state_q == RESP) && (port_q == ARB_PORT_D);

  // Simultaneous load and store is a core bug; the store wins in the decode above.
  a_no_we_and_re : assert property (@(posedge clk_i) disable iff (rst_i)
    !(bus.dmem_we_i && bus.dmem_re_i))
    else $error("dmem_we_i and dmem_re_i asserted together");

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Self-checking bench for rv32i_mem_arbiter: transaction-level reference model plus directed scenarios.
module tb_rv32i_mem_arbiter;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  rv32i_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  rv32i_mem_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rd_data(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0050_0093;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory slave: acks after wait_states cycles of mem_req_o; manual ack when disabled.
  bit slave_en    = 1'b1;
  bit force_ack   = 1'b0;
  int wait_states = 0;
  int wcnt        = 0;

  initial begin
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = 32'hBADB_AD00;
    forever begin
      @(negedge clk_i);
      if (!slave_en) begin
        bus.mem_ack_i   = force_ack;
        bus.mem_rdata_i = 32'h1234_5678;
        wcnt            = 0;
      end else if (bus.mem_req_o && wcnt == wait_states) begin
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = rd_data(bus.mem_add_o);
        wcnt            = 0;
      end else begin
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = 32'hBADB_AD00;
        if (bus.mem_req_o) wcnt++;
      end
    end
  end

  // Reference model: one outstanding transaction, a response cycle, then free again.
  bit          m_busy, m_resp, m_fetch, m_we;
  logic [31:0] m_add, m_wdata, m_idata, m_ddata;
  logic [3:0]  m_ble;
  int          m_starve;

  wire m_data_req = bus.dmem_we_i | bus.dmem_re_i;
`ifdef RV32I_ARB_STARVE_EN
  wire m_force = bus.imem_re_i && (m_starve >= STARVE_MAX);
`else
  wire m_force = 1'b0;
`endif

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_busy <= 1'b0; m_resp <= 1'b0; m_fetch <= 1'b0; m_we <= 1'b0;
      m_add <= '0; m_wdata <= '0; m_ble <= '0; m_idata <= '0; m_ddata <= '0;
      m_starve <= 0;
    end else if (m_resp) begin
      m_resp <= 1'b0;
    end else if (m_busy) begin
      if (bus.mem_ack_i) begin
        m_busy <= 1'b0;
        m_resp <= 1'b1;
        if (m_fetch)    m_idata <= bus.mem_rdata_i;
        else if (!m_we) m_ddata <= bus.mem_rdata_i;
      end
    end else if (m_data_req && !m_force) begin
      m_busy <= 1'b1; m_fetch <= 1'b0; m_we <= bus.dmem_we_i;
      m_add <= bus.dmem_add_i; m_wdata <= bus.dmem_di_i; m_ble <= bus.dmem_ble_i;
      if (bus.imem_re_i && m_starve < STARVE_MAX) m_starve <= m_starve + 1;
    end else if (bus.imem_re_i) begin
      m_busy <= 1'b1; m_fetch <= 1'b1; m_we <= 1'b0;
      m_add <= bus.imem_add_i; m_ble <= 4'hF;
      m_starve <= 0;
    end
  end

  always @(negedge clk_i) begin
    #1;
    check("mem_req",    32'(bus.mem_req_o),    32'(m_busy));
    check("imem_valid", 32'(bus.imem_valid_o), 32'(m_resp && m_fetch));
    check("dmem_valid", 32'(bus.dmem_valid_o), 32'(m_resp && !m_fetch));
    check("imem_data",  bus.imem_data_o, m_idata);
    check("dmem_do",    bus.dmem_do_o,   m_ddata);
    if (m_busy) begin
      check("mem_we",  32'(bus.mem_we_o),  32'(m_we));
      check("mem_add", bus.mem_add_o,      m_add);
      check("mem_ble", 32'(bus.mem_ble_o), 32'(m_ble));
      if (m_we) check("mem_wdata", bus.mem_wdata_o, m_wdata);
    end
  end

  task automatic wait_for(input int which, input int budget, input string name, output int cyc);
    bit ok;
    logic s;
    ok  = 1'b0;
    cyc = 0;
    while (!ok && cyc < budget) begin
      @(negedge clk_i);
      #1;
      cyc++;
      s = (which == 0) ? bus.mem_req_o : (which == 1) ? bus.imem_valid_o : bus.dmem_valid_o;
      if (s) ok = 1'b1;
    end
    check(name, 32'(ok), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  int cyc;
  int n_cyc;
  int nd, nf, d_before;
  bit prev_req;

  initial begin
    bus.imem_add_i = '0; bus.imem_re_i = 1'b0;
    bus.dmem_add_i = '0; bus.dmem_di_i = '0; bus.dmem_we_i = 1'b0;
    bus.dmem_re_i  = 1'b0; bus.dmem_ble_i = '0;
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("rst_mem_req",    32'(bus.mem_req_o),    32'd0);
    check("rst_mem_we",     32'(bus.mem_we_o),     32'd0);
    check("rst_imem_valid", 32'(bus.imem_valid_o), 32'd0);
    check("rst_dmem_valid", 32'(bus.dmem_valid_o), 32'd0);
    check("rst_mem_add",    bus.mem_add_o,         32'd0);
    check("rst_dmem_do",    bus.dmem_do_o,         32'd0);

    // 1: fetch only
    @(negedge clk_i);
    bus.imem_add_i = 32'h100; bus.imem_re_i = 1'b1;
    wait_for(0, 5, "t1_req_seen", cyc);
    check("t1_req_latency", 32'(cyc), 32'd1);
    check("t1_add", bus.mem_add_o, 32'h100);
    check("t1_ble", 32'(bus.mem_ble_o), 32'hF);
    wait_for(1, 5, "t1_valid_seen", cyc);
    check("t1_valid_latency", 32'(cyc), 32'd1);
    check("t1_idata", bus.imem_data_o, 32'h0050_0093);
    check("t1_no_dvalid", 32'(bus.dmem_valid_o), 32'd0);
    bus.imem_re_i = 1'b0;
    @(negedge clk_i); #1;
    check("t1_pulse_one_cycle", 32'(bus.imem_valid_o), 32'd0);

    // 2: fetch and store together, store first
    @(negedge clk_i);
    bus.imem_add_i = 32'h104; bus.imem_re_i = 1'b1;
    bus.dmem_add_i = 32'h2000; bus.dmem_di_i = 32'hDEAD_BEEF;
    bus.dmem_ble_i = 4'b0011;  bus.dmem_we_i = 1'b1;
    wait_for(0, 5, "t2_dreq_seen", cyc);
    check("t2_we",    32'(bus.mem_we_o),  32'd1);
    check("t2_ble",   32'(bus.mem_ble_o), 32'h3);
    check("t2_add",   bus.mem_add_o,      32'h2000);
    check("t2_wdata", bus.mem_wdata_o,    32'hDEAD_BEEF);
    wait_for(2, 5, "t2_dvalid_seen", cyc);
    bus.dmem_we_i = 1'b0;
    check("t2_do_held", bus.dmem_do_o, 32'd0);
    wait_for(0, 6, "t2_ireq_seen", cyc);
    check("t2_fetch_we",  32'(bus.mem_we_o),  32'd0);
    check("t2_fetch_ble", 32'(bus.mem_ble_o), 32'hF);
    check("t2_fetch_add", bus.mem_add_o,      32'h104);
    wait_for(1, 5, "t2_ivalid_seen", cyc);
    check("t2_idata", bus.imem_data_o, 32'h0104_FEFB);
    bus.imem_re_i = 1'b0;

    // 3: load with three wait states
    wait_states = 3;
    @(negedge clk_i);
    bus.dmem_add_i = 32'h3000; bus.dmem_ble_i = 4'hF; bus.dmem_re_i = 1'b1;
    wait_for(0, 5, "t3_req_seen", cyc);
    n_cyc = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i); #1;
      if (!bus.mem_req_o) break;
      n_cyc++;
      check("t3_add_stable", bus.mem_add_o, 32'h3000);
    end
    check("t3_req_cycles", 32'(n_cyc), 32'd4);
    check("t3_dvalid_after_ack", 32'(bus.dmem_valid_o), 32'd1);
    check("t3_ddata", bus.dmem_do_o, 32'h3000_CFFF);
    bus.dmem_re_i = 1'b0;
    wait_states = 0;

    // 4: reset during DGNT, then a stray ack
    slave_en = 1'b0; force_ack = 1'b0;
    @(negedge clk_i);
    bus.dmem_add_i = 32'h4000; bus.dmem_re_i = 1'b1;
    wait_for(0, 5, "t4_req_seen", cyc);
    #1 rst_i = 1'b1;
    #1;
    check("t4_req_drops", 32'(bus.mem_req_o), 32'd0);
    bus.dmem_re_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0; force_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i); #1;
      check("t4_no_dvalid", 32'(bus.dmem_valid_o), 32'd0);
      check("t4_no_ivalid", 32'(bus.imem_valid_o), 32'd0);
      check("t4_no_req",    32'(bus.mem_req_o),    32'd0);
    end
    force_ack = 1'b0;
    @(negedge clk_i);
    slave_en = 1'b1;

    // 5: continuous loads with a pending fetch
    @(negedge clk_i);
    bus.dmem_add_i = 32'h5000; bus.dmem_re_i = 1'b1;
    bus.imem_add_i = 32'h200;  bus.imem_re_i = 1'b1;
    nd = 0; nf = 0; d_before = -1; prev_req = 1'b0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk_i); #1;
      if (bus.mem_req_o && !prev_req) begin
        if (!bus.mem_we_o && bus.mem_ble_o == 4'hF && bus.mem_add_o == 32'h200) begin
          if (nf == 0) d_before = nd;
          nf++;
        end else begin
          nd++;
        end
      end
      prev_req = bus.mem_req_o;
    end
`ifdef RV32I_ARB_STARVE_EN
    check("t5_data_before_fetch", 32'(d_before), 32'd4);
    check("t5_fetch_seen", 32'(nf > 0), 32'd1);
`else
    check("t5_no_fetch_grant", 32'(nf), 32'd0);
    check("t5_data_grants_run", 32'(nd >= 10), 32'd1);
`endif
    bus.dmem_re_i = 1'b0;
    wait_for(1, 15, "t5_fetch_done", cyc);
    check("t5_idata", bus.imem_data_o, 32'h0200_FDFF);
    bus.imem_re_i = 1'b0;
    repeat (3) @(negedge clk_i);

    // 6: load held through RESP
    @(negedge clk_i);
    bus.dmem_add_i = 32'h6000; bus.dmem_re_i = 1'b1;
    wait_for(0, 5, "t6_req_seen", cyc);
    wait_for(2, 5, "t6_dvalid_seen", cyc);
    check("t6_no_grant_in_resp", 32'(bus.mem_req_o), 32'd0);
    @(negedge clk_i); #1;
    check("t6_idle_gap", 32'(bus.mem_req_o), 32'd0);
    @(negedge clk_i); #1;
    check("t6_regrant",     32'(bus.mem_req_o), 32'd1);
    check("t6_regrant_add", bus.mem_add_o,      32'h6000);
    bus.dmem_re_i = 1'b0;
    wait_for(2, 5, "t6_second_dvalid", cyc);
    check("t6_ddata", bus.dmem_do_o, 32'h6000_9FFF);
    repeat (3) @(negedge clk_i);
    #2;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
